// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO with exact fill count, registered thresholds, flush and read-valid strobe.
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int AF_LEVEL = 120,
    parameter int AE_LEVEL = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    input  logic              write_en,
    input  logic              read_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   count
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] ZERO_C  = '0;

    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
        $error("sync_fifo_param: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic              wr_acc, rd_acc;

    // Accept decisions use the registered flags; flush discards both requests.
    always_comb begin
        wr_acc  = write_en & ~full_q & ~flush;
        rd_acc  = read_en & ~empty_q & ~flush;
        wptr_d  = flush ? ZERO_C : wptr_q + {ZERO_C[ADDR_W-1:0], wr_acc};
        rptr_d  = flush ? ZERO_C : rptr_q + {ZERO_C[ADDR_W-1:0], rd_acc};
        count_d = flush ? ZERO_C
                        : count_q + {ZERO_C[ADDR_W-1:0], wr_acc} - {ZERO_C[ADDR_W-1:0], rd_acc};
        dout_d  = rd_acc ? mem_q[rptr_q[ADDR_W-1:0]] : dout_q;
        valid_d = rd_acc;
        full_d  = count_d == DEPTH_C;
        empty_d = count_d == ZERO_C;
        af_d    = count_d >= AF_C;
        ae_d    = count_d <= AE_C;
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc)
            mem_q[wptr_q[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Sticky error bits; flush clears them even if an error occurs in the same cycle.
    always_comb begin
        ovf_d = ~flush & (ovf_q | (write_en & full_q));
        unf_d = ~flush & (unf_q | (read_en & empty_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif
endmodule
